// File: rtl/sc_io_datamem_if.sv
// ----------------------------------------------------------------------------
// sc_io_datamem_if
//   Load/store bus between the single-cycle core datapath and the data-side
//   memory / memory-mapped I/O stage. The bus has no handshake: a store
//   commits on the next rising clock edge, and a load returns in the same
//   cycle.
//
//   Signals:
//     addr  : byte address taken from the ALU result
//     wdata : store data (rs2 value)
//     wmem  : store enable
//     rdata : load data, driven combinationally from addr by the slave
//
//   Modports:
//     master : the core; drives addr, wdata and wmem
//     slave  : the memory stage; drives rdata
// ----------------------------------------------------------------------------
interface sc_io_datamem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wmem, input rdata);
    modport slave  (input addr, input wdata, input wmem, output rdata);
endinterface

// File: rtl/sc_io_datamem.sv
// ----------------------------------------------------------------------------
// sc_io_datamem
//   Data-side memory and memory-mapped I/O stage of the single-cycle RISC-V
//   core. It contains a word-addressed data RAM and a small I/O register
//   file. The register file covers switches, keys, LEDs, a hex display, a
//   free-running cycle counter and a compare timer. Loads are combinational,
//   and stores commit on the rising edge of clock.
//
//   Address map:
//     addr[31:8]==0 && addr[7]==1 : I/O registers, offset addr[6:0]
//       0x00 SW    RO  synchronised switches
//       0x04 KEY   RO  synchronised keys (plus press latches, see below)
//       0x08 LED   RW
//       0x0C HEX   RW  six 4-bit digits
//       0x10 CYCLE RW  free-running counter; a write loads it
//       0x14 TCMP  RW  timer compare; a write restarts the timer count
//       0x18 TSTAT W1C bit0 = expired
//     anything else : RAM word addr[RAM_AW+1:2]; upper bits alias
//
//   Ports:
//     clock     : system clock, rising edge
//     resetn    : asynchronous active-low reset
//     bus       : load/store bus (slave modport)
//     sw_in     : raw asynchronous switch pins
//     key_in    : raw asynchronous keys, active high
//     led_out   : LED register
//     hex_out   : hex digit register, digit0 in [3:0]
//     timer_irq : level copy of the timer expired flag
//
//   Optional build macro:
//     SC_IO_KEY_EDGE_EN : adds sticky key-press latches in KEY[7:4].
//     These latches are cleared by writing 1 to the matching bits of KEY.
// ----------------------------------------------------------------------------
module sc_io_datamem #(
    parameter int RAM_AW = 6,
    parameter int SW_W   = 10,
    parameter int LED_W  = 10
) (
    input  logic              clock,
    input  logic              resetn,
    sc_io_datamem_if.slave    bus,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [3:0]        key_in,
    output logic [LED_W-1:0]  led_out,
    output logic [23:0]       hex_out,
    output logic              timer_irq
);

    // I/O register word offsets (addr[6:2]).
    typedef enum logic [4:0] {
        REG_SW    = 5'h00,
        REG_KEY   = 5'h01,
        REG_LED   = 5'h02,
        REG_HEX   = 5'h03,
        REG_CYCLE = 5'h04,
        REG_TCMP  = 5'h05,
        REG_TSTAT = 5'h06
    } io_reg_e;

    // ---------------------------------------------------------------- decode
    logic              io_sel;
    logic [4:0]        io_word;
    logic [RAM_AW-1:0] ram_idx;
    logic              io_we;
    logic              ram_we;

    assign io_sel  = (bus.addr[31:8] == 24'h0) && bus.addr[7];
    assign io_word = bus.addr[6:2];
    assign ram_idx = bus.addr[RAM_AW+1:2];
    assign io_we   = bus.wmem && io_sel;
    assign ram_we  = bus.wmem && !io_sel;

    // The core issues word accesses only, so the byte offset is unused.
    logic unused_byte_offset;
    assign unused_byte_offset = ^bus.addr[1:0];

    // ---------------------------------------------------------------- RAM
    logic [31:0] mem [2**RAM_AW];

    // NOTE: the RAM array has no reset branch. This lets it map onto plain
    // memory. Software must store a word before it loads that word.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.wdata;
        end
    end

    // ---------------------------------------------------------- synchronisers
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [3:0]      key_s1, key_s2;

    // NOTE: sequential state always uses non-blocking assignments. This way
    // every flop samples the values from before the edge, and the two-stage
    // synchroniser really is two stages.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    // ---------------------------------------------------------- I/O registers
    logic [LED_W-1:0] led;
    logic [23:0]      hex;
    logic [31:0]      cycle;
    logic [31:0]      tcmp;
    logic [31:0]      tcnt;
    logic             expired;

    logic led_we, hex_we, cycle_we, tcmp_we, tstat_clr;
    logic expire_evt;

    assign led_we    = io_we && (io_word == REG_LED);
    assign hex_we    = io_we && (io_word == REG_HEX);
    assign cycle_we  = io_we && (io_word == REG_CYCLE);
    assign tcmp_we   = io_we && (io_word == REG_TCMP);
    assign tstat_clr = io_we && (io_word == REG_TSTAT) && bus.wdata[0];

    // A zero compare value parks the timer, so a match counts only when
    // the compare value is non-zero.
    assign expire_evt = (tcmp != 32'h0) && (tcnt == tcmp);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led     <= '0;
            hex     <= '0;
            cycle   <= '0;
            tcmp    <= '0;
            tcnt    <= '0;
            expired <= 1'b0;
        end else begin
            if (led_we) led <= bus.wdata[LED_W-1:0];
            if (hex_we) hex <= bus.wdata[23:0];

            // A software load of the counter takes priority over the increment.
            cycle <= cycle_we ? bus.wdata : cycle + 32'd1;

            // Writing the compare value restarts the count. A match also
            // reloads the count, so the timer period is TCMP+1 clocks.
            if (tcmp_we) begin
                tcmp <= bus.wdata;
                tcnt <= '0;
            end else if (tcmp == 32'h0 || expire_evt) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 32'd1;
            end

            // Set beats clear, so an expiry that lands on a clear is not lost.
            expired <= expire_evt || (expired && !tstat_clr);
        end
    end

    assign led_out   = led;
    assign hex_out   = hex;
    assign timer_irq = expired;

    // ------------------------------------------------------------ key value
    logic [31:0] key_value;

`ifdef SC_IO_KEY_EDGE_EN
    logic [3:0] key_d;
    logic [3:0] key_evt;
    logic [3:0] key_rise;
    logic [3:0] key_clr;

    assign key_rise = key_s2 & ~key_d;
    assign key_clr  = (io_we && (io_word == REG_KEY)) ? bus.wdata[7:4] : 4'h0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_d   <= '0;
            key_evt <= '0;
        end else begin
            key_d   <= key_s2;
            key_evt <= key_rise | (key_evt & ~key_clr);
        end
    end

    assign key_value = {24'h0, key_evt, key_s2};
`else
    assign key_value = {28'h0, key_s2};
`endif

    // ------------------------------------------------------------- read mux
    logic [31:0] io_rdata;

    // NOTE: the combinational read mux assigns a default value first. Every
    // path then drives io_rdata, so no latch can be inferred for the
    // unmapped offsets.
    always_comb begin
        io_rdata = 32'h0;
        case (io_word)
            REG_SW:    io_rdata = {{(32-SW_W){1'b0}}, sw_s2};
            REG_KEY:   io_rdata = key_value;
            REG_LED:   io_rdata = {{(32-LED_W){1'b0}}, led};
            REG_HEX:   io_rdata = {8'h0, hex};
            REG_CYCLE: io_rdata = cycle;
            REG_TCMP:  io_rdata = tcmp;
            REG_TSTAT: io_rdata = {31'h0, expired};
            default:   io_rdata = 32'h0;
        endcase
    end

    assign bus.rdata = io_sel ? io_rdata : mem[ram_idx];

endmodule

// File: tb/tb_sc_io_datamem.sv
// ----------------------------------------------------------------------------
// tb_sc_io_datamem
//   Directed bench for sc_io_datamem. Inputs change on the falling edge of
//   the clock. Outputs are sampled 1 time unit later, well away from the
//   rising edge where state updates. Expected values are hand-computed
//   constants.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_io_datamem;

    logic        clock;
    logic        resetn;
    logic [9:0]  sw_in;
    logic [3:0]  key_in;
    logic [9:0]  led_out;
    logic [23:0] hex_out;
    logic        timer_irq;

    sc_io_datamem_if bus ();

    sc_io_datamem #(.RAM_AW(6), .SW_W(10), .LED_W(10)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus.slave),
        .sw_in     (sw_in),
        .key_in    (key_in),
        .led_out   (led_out),
        .hex_out   (hex_out),
        .timer_irq (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advance to the next falling edge; exactly one rising edge passes.
    task automatic tick();
        @(negedge clock);
    endtask

    // Called at a falling edge. The store commits on the following rising
    // edge, and the task returns at the next falling edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wmem  = 1'b1;
        tick();
        bus.wmem  = 1'b0;
    endtask

    // Combinational load, performed with no edge in between.
    task automatic load(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.wmem = 1'b0;
        #1;
        d = bus.rdata;
    endtask

    logic [31:0] rd;
    logic [31:0] key_evt_exp;

    initial begin
        resetn    = 1'b0;
        sw_in     = '0;
        key_in    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wmem  = 1'b0;
`ifdef SC_IO_KEY_EDGE_EN
        key_evt_exp = 32'h40;
`else
        key_evt_exp = 32'h00;
`endif

        // ---------------- reset state
        #2;
        check("rst_led", {22'h0, led_out}, 32'h0);
        check("rst_hex", {8'h0, hex_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        load(32'h90, rd);
        check("rst_cycle", rd, 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // ---------------- 1: RAM store/load and aliasing
        store(32'h04, 32'hDEADBEEF);
        load(32'h04, rd);
        check("ram_rd", rd, 32'hDEADBEEF);
        load(32'h104, rd);
        check("ram_alias", rd, 32'hDEADBEEF);
        load(32'h07, rd);
        check("ram_byteoff", rd, 32'hDEADBEEF);
        tick();

        // ---------------- 2: switch synchroniser, LED, async reset
        sw_in = 10'h2A5;
        load(32'h80, rd);
        check("sw_lat0", rd, 32'h0);
        tick();
        load(32'h80, rd);
        check("sw_lat1", rd, 32'h0);
        tick();
        load(32'h80, rd);
        check("sw_lat2", rd, 32'h2A5);

        store(32'h88, 32'h3FF);
        check("led_set", {22'h0, led_out}, 32'h3FF);
        load(32'h88, rd);
        check("led_rd", rd, 32'h3FF);
        store(32'h8C, 32'h00ABCD);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_led", {22'h0, led_out}, 32'h0);
        check("rst_mid_hex", {8'h0, hex_out}, 32'h0);
        tick();
        resetn = 1'b1;
        load(32'h04, rd);
        check("ram_keeps", rd, 32'hDEADBEEF);
        tick();

        // ---------------- 3: HEX, unmapped I/O offset
        store(32'h8C, 32'h123456);
        check("hex_set", {8'h0, hex_out}, 32'h123456);
        store(32'h88, 32'h155);
        store(32'h1A0, 32'h11111111);   // RAM word that would alias 0xA0
        store(32'hA0, 32'h55AA55AA);
        load(32'hA0, rd);
        check("unmapped_rd", rd, 32'h0);
        load(32'h1A0, rd);
        check("unmapped_ram", rd, 32'h11111111);
        check("unmapped_led", {22'h0, led_out}, 32'h155);
        check("unmapped_hex", {8'h0, hex_out}, 32'h123456);
        tick();

        // ---------------- 4: compare timer
        store(32'h94, 32'd4);
        load(32'h94, rd);
        check("tcmp_rd", rd, 32'd4);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("tmr_a%0d", i), {31'h0, timer_irq}, 32'h0);
            tick();
        end
        check("tmr_a_exp", {31'h0, timer_irq}, 32'h1);
        load(32'h98, rd);
        check("tstat_rd", rd, 32'h1);
        // The clear lands one edge after expiry; the next expiry comes one
        // full period (5 clocks) after the previous one.
        store(32'h98, 32'h1);
        check("tmr_clr", {31'h0, timer_irq}, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("tmr_b%0d", i), {31'h0, timer_irq}, 32'h0);
        end
        tick();
        check("tmr_b_exp", {31'h0, timer_irq}, 32'h1);
        // Clear again, then write the clear exactly on the next expiry edge.
        store(32'h98, 32'h1);
        check("tmr_clr2", {31'h0, timer_irq}, 32'h0);
        tick();
        tick();
        tick();
        check("tmr_c_pre", {31'h0, timer_irq}, 32'h0);
        store(32'h98, 32'h1);
        check("tmr_set_wins", {31'h0, timer_irq}, 32'h1);
        store(32'h94, 32'd0);
        store(32'h98, 32'h1);
        for (int i = 0; i < 8; i++) tick();
        check("tmr_off", {31'h0, timer_irq}, 32'h0);

        // ---------------- 5: cycle counter load and wrap
        store(32'h90, 32'hFFFFFFFE);
        load(32'h90, rd);
        check("cyc_0", rd, 32'hFFFFFFFE);
        tick();
        load(32'h90, rd);
        check("cyc_1", rd, 32'hFFFFFFFF);
        tick();
        load(32'h90, rd);
        check("cyc_wrap", rd, 32'h0);
        tick();

        // ---------------- 6: key synchroniser and optional press latch
        key_in = 4'b0100;
        tick();
        key_in = 4'b0000;
        load(32'h84, rd);
        check("key_lat1", rd, 32'h0);
        tick();
        load(32'h84, rd);
        check("key_raw", rd, 32'h4);
        tick();
        load(32'h84, rd);
        check("key_evt", rd, key_evt_exp);
        tick();
        tick();
        load(32'h84, rd);
        check("key_sticky", rd, key_evt_exp);
        store(32'h84, 32'h40);
        load(32'h84, rd);
        check("key_clr", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
